// File: rtl/tick_pulse_stretcher_pkg.sv
// Shared pulse-driver definitions: state encoding, default timing and counter sizing.
// Used by tick_pulse_stretcher and the other output drivers (LED blinker, buzzer).
package vm_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_HIGH_CYCLES = 25_000_000;
  localparam int unsigned DEFAULT_LOW_CYCLES  = 25_000_000;
  localparam int unsigned DEFAULT_PEND_W      = 4;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/tick_pulse_stretcher_if.sv
// Tick request / stretched pulse bundle between the vending FSM side and the pulse stretcher.
interface tick_pulse_stretcher_if
  import vm_pulse_pkg::*;
#(
  parameter int unsigned PEND_W = DEFAULT_PEND_W
);
  logic              tick;
  logic              ovf_clr;
  logic              level_out;
  logic              busy;
  logic              done;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output tick, ovf_clr,
    input  level_out, busy, done, pending, overflow
  );

  modport slave (
    input  tick, ovf_clr,
    output level_out, busy, done, pending, overflow
  );
endinterface

// File: rtl/tick_pulse_stretcher_load_down_counter.sv
// Loadable down-counter that holds at zero; zero_next exposes the value after the coming edge.
module load_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero,
  output logic             zero_next
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero      = (cnt_q == '0);
  assign zero_next = (cnt_d == '0);
endmodule

// File: rtl/tick_pulse_stretcher.sv
// Stretches single-cycle ticks into HIGH_CYCLES-high / LOW_CYCLES-low pulse periods.
// Define TICK_PULSE_QUEUE_EN to queue ticks that arrive while busy; otherwise they are dropped.
module tick_pulse_stretcher
  import vm_pulse_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEFAULT_LOW_CYCLES,
  parameter int unsigned PEND_W      = DEFAULT_PEND_W
) (
  input logic                 clk,
  input logic                 reset,
  tick_pulse_stretcher_if.slave bus
);
  localparam int unsigned      CNT_W     = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
`ifdef TICK_PULSE_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero, cnt_zero_next;
  logic             last_low, pend_nz, req, drop;
  logic             level_q, busy_q, done_q, ovf_q;

  load_down_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .zero      (cnt_zero),
    .zero_next (cnt_zero_next)
  );

  assign last_low = (state_q == LOW) && cnt_zero;
  // Busy-time tick is a queue request unless it directly restarts an empty queue at LOW end.
  assign req = bus.tick && (state_q != IDLE) && !(QUEUE_EN && last_low && !pend_nz);

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = HIGH_LOAD;
    unique case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          state_d      = LOW;
          cnt_load     = 1'b1;
          cnt_load_val = LOW_LOAD;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          if (pend_nz || (QUEUE_EN && bus.tick)) begin
            state_d  = HIGH;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TICK_PULSE_QUEUE_EN
  localparam logic [PEND_W-1:0] MAX_PEND = '1;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              pend_dec, accept;

  assign pend_dec = last_low && pend_nz;
  // A restart frees one slot in the same cycle, so a full queue still accepts then.
  assign accept   = req && ((pending_q != MAX_PEND) || pend_dec);
  assign drop     = req && !accept;

  always_comb begin
    pending_d = pending_q;
    if (accept && !pend_dec) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!accept && pend_dec) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pend_nz     = (pending_q != '0);
  assign bus.pending = pending_q;
`else
  assign pend_nz     = 1'b0;
  assign drop        = req;
  assign bus.pending = {PEND_W{1'b0}};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == LOW) && cnt_zero_next;
      ovf_q   <= drop | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_tick_pulse_stretcher.sv
// Bench for tick_pulse_stretcher: vector tables, directed corner sequences and a random run
// checked every cycle against a pulse-period reference model.
module tb_tick_pulse_stretcher;
  localparam int unsigned H    = 3;
  localparam int unsigned L    = 2;
  localparam int unsigned PW   = 2;
  localparam int          MAXP = 3;
`ifdef TICK_PULSE_QUEUE_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  tick_pulse_stretcher_if #(.PEND_W(PW)) bus ();

  tick_pulse_stretcher #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position inside the current H+L period (-1 when idle), queued count, sticky flag.
  typedef struct {
    int pos;
    int pend;
    bit ovf;
  } model_t;

  typedef struct {
    bit tick;
    bit clr;
    bit lvl;
    bit busy;
    bit done;
    int pend;
    bit ovf;
  } row_t;

  model_t m = '{pos: -1, pend: 0, ovf: 1'b0};

  function automatic model_t model_next(model_t c, bit t, bit clr);
    model_t n;
    bit     drop;
    n    = c;
    drop = 1'b0;
    if (c.pos < 0) begin
      if (t) n.pos = 0;
    end else if (c.pos == int'(H + L) - 1) begin
      if (Q && c.pend > 0) begin
        n.pos = 0;
        if (!t) n.pend = c.pend - 1;
      end else if (Q && t) begin
        n.pos = 0;
      end else begin
        n.pos = -1;
        drop  = t;
      end
    end else begin
      n.pos = c.pos + 1;
      if (t) begin
        if (Q && c.pend < MAXP) n.pend = c.pend + 1;
        else drop = 1'b1;
      end
    end
    if (drop) n.ovf = 1'b1;
    else if (clr) n.ovf = 1'b0;
    return n;
  endfunction

  function automatic logic [5:0] pack(bit lvl, bit busy, bit done, int pend, bit ovf);
    return {lvl, busy, done, pend[1:0], ovf};
  endfunction

  function automatic logic [5:0] model_outs(model_t c);
    return pack(c.pos >= 0 && c.pos < int'(H), c.pos >= 0, c.pos == int'(H + L) - 1,
                c.pend, c.ovf);
  endfunction

  function automatic logic [5:0] dut_outs();
    return {bus.level_out, bus.busy, bus.done, bus.pending, bus.overflow};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{pos: -1, pend: 0, ovf: 1'b0};
    else m <= model_next(m, bus.tick, bus.ovf_clr);
  end

  // Continuous comparison {level,busy,done,pending,overflow} against the model.
  always @(negedge clk) begin
    if (!reset) chk("model", int'(dut_outs()), int'(model_outs(m)));
  end

  task automatic drive(bit t, bit c);
    bus.tick    = t;
    bus.ovf_clr = c;
    @(negedge clk);
  endtask

  task automatic apply_rows(string name, row_t rows[$]);
    foreach (rows[i]) begin
      drive(rows[i].tick, rows[i].clr);
      chk($sformatf("%s[%0d]", name, i), int'(dut_outs()),
          int'(pack(rows[i].lvl, rows[i].busy, rows[i].done, rows[i].pend, rows[i].ovf)));
    end
  endtask

  task automatic async_reset_pulse(string name);
    #2 reset = 1'b1;
    #1 chk(name, int'(dut_outs()), 0);
    #1 reset = 1'b0;
  endtask

  row_t single[$];
  row_t lastlow[$];

  initial begin
    single = '{
      '{1, 0, 1, 1, 0, 0, 0},
      '{0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 0, 1, 0, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0}
    };
    lastlow = '{
      '{1, 0, 1, 1, 0, 0, 0},
      '{0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 0, 1, 0, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{1, 0, Q, Q, 0, 0, !Q},
      '{0, 0, Q, Q, 0, 0, !Q},
      '{0, 0, Q, Q, 0, 0, !Q},
      '{0, 0, 0, Q, 0, 0, !Q},
      '{0, 0, 0, Q, Q, 0, !Q},
      '{0, 0, 0, 0, 0, 0, !Q},
      '{0, 1, 0, 0, 0, 0, 0}
    };

    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.ovf_clr = 1'b0;
    #7 chk("reset_state", int'(dut_outs()), 0);
    @(negedge clk);
    reset = 1'b0;

    apply_rows("single", single);
    apply_rows("lastlow", lastlow);

    // Ticks at relative cycles 0, 2, 3: two queue behind the first pulse.
    drive(1, 0);
    drive(0, 0);
    drive(1, 0);
    drive(1, 0);
    chk("three_pending", int'(bus.pending), Q ? 2 : 0);
    chk("three_ovf", int'(bus.overflow), Q ? 0 : 1);
    repeat (20) drive(0, 0);
    chk("three_drained", int'({bus.busy, bus.pending}), 0);
    drive(0, 1);

    // Saturation, clear, then clear coincident with a drop.
    repeat (5) drive(1, 0);
    chk("sat_pending", int'(bus.pending), Q ? MAXP : 0);
    chk("sat_ovf", int'(bus.overflow), 1);
    drive(0, 1);
    chk("clr_ovf", int'(bus.overflow), 0);
    drive(1, 0);
    drive(1, 1);
    chk("clr_vs_drop", int'(bus.overflow), 1);
    repeat (30) drive(0, 0);
    drive(0, 1);

    // Asynchronous reset mid-HIGH with queued ticks.
    drive(1, 0);
    drive(1, 0);
    drive(1, 0);
    chk("pre_reset_pending", int'(bus.pending), Q ? 2 : 0);
    async_reset_pulse("midhigh_reset");
    apply_rows("after_reset", single);

    for (int i = 0; i < 3000; i++) begin
      int tick_pct;
      tick_pct = (i / 500) % 2 == 0 ? 30 : 60;
      if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_reset");
      drive($urandom_range(0, 99) < tick_pct, $urandom_range(0, 99) < 5);
    end
    drive(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_pulse_stretcher.md
Name: tick_pulse_stretcher

Overview:
- Converts single-cycle internal event ticks into fixed-width, human/actuator-visible level pulses. Typical loads are a dispense solenoid, a coin-return actuator or a status LED.
- Sits on the output side of the vending controller, downstream of the FSM that consumes debounced button ticks.
- Every accepted tick produces exactly one HIGH window followed by a mandatory LOW gap.
- Ticks that arrive while a pulse is in progress are queued up to a bounded depth.

Parameters:
- HIGH_CYCLES, 25_000_000, clk cycles level_out is held high per pulse (>=1).
- LOW_CYCLES, 25_000_000, clk cycles of forced low gap after each pulse (>=1).
- PEND_W, 4, width of pending-tick counter; queue depth MAX_PEND = 2**PEND_W - 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle event request.
- ovf_clr  input  1  synchronous clear of the sticky overflow flag.
- level_out  output  1  stretched pulse, registered.
- busy  output  1  high whenever state != IDLE, registered.
- done  output  1  one-cycle pulse on the final LOW cycle of each pulse period.
- pending  output  PEND_W  number of queued, not-yet-started pulses.
- overflow  output  1  sticky; set when a tick is dropped.

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Reset values: state=IDLE, cnt=0, level_out=0, busy=0, done=0, pending=0, overflow=0. Reset mid-pulse aborts immediately. Queued ticks are discarded.
- States:
  - IDLE: level_out=0.
  - HIGH: level_out=1.
  - LOW: level_out=0.
- Counter: cnt is a down-counter of width $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1).
- IDLE:
  - tick=1 -> next state HIGH, cnt<=HIGH_CYCLES-1.
  - level_out rises on the clock edge after the tick (latency 1 cycle).
- HIGH:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> next state LOW, cnt<=LOW_CYCLES-1.
  - level_out is therefore high for exactly HIGH_CYCLES cycles.
- LOW:
  - cnt!=0 -> cnt decrements.
  - cnt==0 (last LOW cycle) -> done=1 that cycle.
  - Last LOW cycle, and (pending!=0 or tick=1) -> next state HIGH, cnt<=HIGH_CYCLES-1; otherwise -> IDLE.
  - Back-to-back pulses are therefore separated by exactly LOW_CYCLES low cycles.
- Pending arithmetic, per cycle:
  - inc = tick and state!=IDLE, excluding the start-consuming case below.
  - dec = the LOW-end restart was taken using a queued entry.
  - On the LOW-end cycle with tick=1 and pending!=0: pending is unchanged (one queued entry consumed, the new tick queued).
  - On the LOW-end cycle with tick=1 and pending==0: the tick starts the pulse directly and pending stays 0.
  - inc when pending==MAX_PEND: tick dropped, pending stays MAX_PEND, overflow<=1.
- Overflow:
  - ovf_clr=1 clears overflow.
  - Simultaneous drop and ovf_clr -> overflow stays 1; set wins.
- tick held high for multiple cycles: each cycle is a separate request. Upstream guarantees single-cycle ticks.
- done, busy and level_out are all registered outputs with no combinational input-to-output path.

Optional Feature:
- Macro: TICK_PULSE_QUEUE_EN.
- Defined: queuing behaves as described in Behaviour.
- Undefined:
  - The pending register is removed and the pending output is tied to 0.
  - Any tick with state!=IDLE is dropped and sets overflow.
  - A tick on the last LOW cycle is also dropped; the block returns to IDLE.
  - IDLE, HIGH and LOW timing is unchanged.

Decomposition:
- Shared package vm_pulse_pkg holds:
  - State encoding constants: IDLE=2'b00, HIGH=2'b01, LOW=2'b10.
  - Default timing constants, shared with other output drivers (LED blinker, buzzer).
- One natural sub-module, load_down_counter:
  - Parameterised width.
  - Inputs load and load_val.
  - Output zero.
  - Instantiated once for cnt.

Test Plan (HIGH_CYCLES=3, LOW_CYCLES=2, PEND_W=2, MAX_PEND=3):
- Single tick at cycle 10 -> level_out=1 on cycles 11–13, 0 on 14–15; done=1 at cycle 15; busy=1 on cycles 11–15; IDLE at cycle 16.
- Ticks at cycles 10, 12, 13 -> pending reaches 2; three pulses start at cycles 11, 16 and 21, each 3 high / 2 low; done at 15, 20, 25; pending ends at 0.
- Tick exactly on the last LOW cycle (cycle 15) with pending=0 -> HIGH resumes at 16 with no IDLE gap; pending stays 0.
- Five ticks during one HIGH window -> pending saturates at 3 and overflow=1. Then ovf_clr pulse -> overflow=0. Ovf_clr coincident with a drop -> overflow stays 1.
- reset asserted at cycle 12 mid-HIGH with pending=2 -> all outputs 0 immediately, asynchronously; the next tick after release produces a normal 3-cycle pulse.
- With TICK_PULSE_QUEUE_EN undefined: ticks at cycles 10 and 12 -> one pulse only, overflow=1, pending stays 0.
